// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: divider state encoding and default operand width.
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } div_state_t;

endpackage

// File: rtl/trial_sub.sv
// Combinational W-bit subtract a - b, built as a + ~b + 1 on a ripple-carry chain.
module trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] w_b_n;
  logic [W:0]   w_carry;

  assign w_b_n      = ~b;
  assign w_carry[0] = 1'b1;

  for (genvar gi = 0; gi < W; gi++) begin : g_rca
    assign diff[gi]       = a[gi] ^ w_b_n[gi] ^ w_carry[gi];
    assign w_carry[gi+1]  = (a[gi] & w_b_n[gi]) | (w_carry[gi] & (a[gi] ^ w_b_n[gi]));
  end

  // A missing carry-out of the inverted-operand add means a < b.
  assign borrow = ~w_carry[W];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake;
// one quotient bit per clock, results held until the next accepted start.
module restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_t;
  logic             w_borrow;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  logic             w_div0;
  logic             w_busy;
  logic             w_done;
  logic             w_unused;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  assign w_rs = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

  trial_sub #(.W(WIDTH + 1)) u_trial_sub (
    .a      (w_rs),
    .b      ({1'b0, r_d}),
    .diff   (w_t),
    .borrow (w_borrow)
  );

  assign w_r_next = w_borrow ? w_rs : w_t;
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_div0   = (divisor == '0);
  // The partial remainder never exceeds WIDTH bits, so its top bit is never consumed.
  assign w_unused = r_r[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (start) begin
          w_state_next = w_div0 ? S_DONE : S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (w_div0) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_q   <= dividend;
              r_r   <= '0;
              r_d   <= divisor;
              r_cnt <= '0;
            end
          end
        end
        S_RUN: begin
          r_r   <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next[WIDTH-1:0];
            r_dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: cycle-level behavioural model plus
// directed vectors with literal expectations and an exhaustive 4-bit sweep.
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Behavioural model: a running operation lasts W cycles, its result is
  // plain integer division, and outputs hold between completions.
  int           m_left;
  logic         m_done;
  logic         m_z;
  logic [W-1:0] m_q;
  logic [W-1:0] m_r;
  logic [W-1:0] p_q;
  logic [W-1:0] p_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_z    <= 1'b0;
      p_q    <= '0;
      p_r    <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
          m_z    <= 1'b0;
        end
      end else if (start) begin
        if (divisor == 0) begin
          m_done <= 1'b1;
          m_q    <= '1;
          m_r    <= dividend;
          m_z    <= 1'b1;
        end else begin
          m_left <= W;
          p_q    <= dividend / divisor;
          p_r    <= dividend % divisor;
        end
      end
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !==
        {(m_left != 0), m_done, m_q, m_r, m_z}) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t got busy=%b done=%b q=%0d r=%0d z=%b expected busy=%b done=%b q=%0d r=%0d z=%b",
               $time, busy, done, quotient, remainder, div_by_zero,
               (m_left != 0), m_done, m_q, m_r, m_z);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // k = index of the edge (0 = accept edge) after which done is seen; -1 on timeout.
  task automatic wait_done(output int k);
    k = -1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic check_res(input string nm, input int k, input int exp_k,
                           input int eq, input int er, input int ez);
    chk({nm, "_done_edge"}, k, exp_k);
    chk({nm, "_busy_in_done"}, int'(busy), 0);
    chk({nm, "_q"}, int'(quotient), eq);
    chk({nm, "_r"}, int'(remainder), er);
    chk({nm, "_dbz"}, int'(div_by_zero), ez);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_k,
                    input int eq, input int er, input int ez, input string nm);
    int k;
    start_op(a, b);
    wait_done(k);
    check_res(nm, k, exp_k, eq, er, ez);
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    op(4'd13, 4'd3, 4, 4, 1, 0, "d13_3");
    op(4'd15, 4'd1, 4, 15, 0, 0, "d15_1");
    op(4'd2, 4'd9, 4, 0, 2, 0, "d2_9");
    op(4'd0, 4'd5, 4, 0, 0, 0, "d0_5");
    op(4'd7, 4'd0, 0, 15, 7, 1, "d7_0");

    // A start while busy is dropped; the original operation completes on time.
    start_op(4'd13, 4'd3);
    @(posedge clk);
    #1;
    start_op(4'd9, 4'd2);
    wait_done(k);
    check_res("ignored_start", k, 2, 4, 1, 0);
    op(4'd9, 4'd2, 4, 4, 1, 0, "b2b_9_2");

    // Asynchronous reset in the middle of an operation.
    start_op(4'd14, 4'd4);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_q", int'(quotient), 0);
    chk("midrst_r", int'(remainder), 0);
    chk("midrst_dbz", int'(div_by_zero), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    op(4'd14, 4'd4, 4, 3, 2, 0, "after_rst");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          op(W'(a), W'(b), 0, 15, a, 1, "exh");
        else
          op(W'(a), W'(b), 4, a / b, a % b, 0, "exh");
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
